tuner_cic_decimator: RTL

Four-stage CIC decimator sitting directly downstream of the tuner mixer. One instance runs on the I path and one on the Q path. It takes the mixer's 16-bit signed baseband stream at the sample clock and decimates it by a runtime-selectable ratio R (2..64). It then applies a runtime-selectable power-of-two gain correction with round-half-up and saturation, and emits 16-bit samples with a one-cycle valid strobe.

---
 rtl/tuner_cic_decimator_if.sv | 23 ++
 rtl/tuner_cic_decimator.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/tuner_cic_decimator_if.sv
// Sample-stream interface between the tuner mixer and the CIC decimator.
// The master drives input samples and configuration. The slave (the decimator)
// returns decimated samples with a one-cycle valid strobe.
interface tuner_cic_decimator_if #(
    parameter int DSZ = 16
);
    logic signed [DSZ-1:0] in;
    logic                  in_valid;
    logic        [6:0]     ratio;
    logic        [4:0]     shift;
    logic signed [DSZ-1:0] out;
    logic                  out_valid;

    modport master (
        output in, in_valid, ratio, shift,
        input  out, out_valid
    );

    modport slave (
        input  in, in_valid, ratio, shift,
        output out, out_valid
    );
endinterface

// File: rtl/tuner_cic_decimator.sv
// N-stage CIC decimator for one (I or Q) tuner path.
// Ratio R is selectable at runtime in the range 2..RMAX. A power-of-two gain
// correction follows, with round-half-up and saturation to DSZ bits.
// Pipeline: input register -> N integrators -> period capture -> N combs -> output.
module tuner_cic_decimator #(
    parameter int DSZ  = 16,
    parameter int N    = 4,
    parameter int RMAX = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    tuner_cic_decimator_if.slave bus
);
    localparam int LOGR  = $clog2(RMAX);
    localparam int W     = DSZ + N * LOGR;
    localparam int CW    = LOGR;
    localparam int RW    = LOGR + 1;
    localparam int SHMAX = N * LOGR;

    localparam logic [RW-1:0]       RMIN_V = RW'(2);
    localparam logic [RW-1:0]       RMAX_V = RW'(RMAX);
    localparam logic signed [W-1:0] OMAX   = {{(W-DSZ+1){1'b0}}, {(DSZ-1){1'b1}}};
    localparam logic signed [W-1:0] OMIN   = {{(W-DSZ+1){1'b1}}, {(DSZ-1){1'b0}}};

    logic signed [DSZ-1:0] in_p0;
    logic signed [W-1:0]   in_ext;
    logic        [N+1:1]   vld;
    logic signed [W-1:0]   integ [1:N];
    logic        [CW-1:0]  cnt;
    logic        [RW-1:0]  r_act;
    logic                  r_load;
    logic                  period_end;
    logic signed [W-1:0]   comb_in;
    logic        [N+1:1]   stb;
    logic signed [W-1:0]   comb [1:N];
    logic signed [W-1:0]   dly  [1:N];
    logic signed [DSZ-1:0] out_q;
    logic                  out_valid_q;

    function automatic logic [RW-1:0] clamp_ratio(input logic [RW-1:0] r);
        if (r < RMIN_V) return RMIN_V;
        if (r > RMAX_V) return RMAX_V;
        return r;
    endfunction

    // Add half an LSB of the result, then arithmetic shift (round half toward +inf).
    function automatic logic signed [W-1:0] round_shift(input logic signed [W-1:0] v,
                                                        input logic [4:0] sh);
        logic [4:0]          s;
        logic signed [W-1:0] bias;
        s    = (sh > 5'(SHMAX)) ? 5'(SHMAX) : sh;
        bias = '0;
        if (s != 5'd0) bias = W'(1) << (s - 5'd1);
        return (v + bias) >>> s;
    endfunction

    function automatic logic signed [DSZ-1:0] saturate(input logic signed [W-1:0] v);
        if (v > OMAX) return OMAX[DSZ-1:0];
        if (v < OMIN) return OMIN[DSZ-1:0];
        return v[DSZ-1:0];
    endfunction

    assign in_ext     = {{(W-DSZ){in_p0[DSZ-1]}}, in_p0};
    assign period_end = vld[N+1] && (cnt == CW'(r_act - RW'(1)));

    // Input register and valid token chain; the token advances every clock, gap or not
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_p0 <= '0;
            vld   <= '0;
        end else begin
            vld <= {vld[N:1], bus.in_valid};
            if (bus.in_valid) in_p0 <= bus.in;
        end
    end

    // Integrator cascade: modular W-bit accumulation, each stage gated by its token
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 1; k <= N; k++) integ[k] <= '0;
        end else begin
            if (vld[1]) integ[1] <= integ[1] + in_ext;
            for (int k = 2; k <= N; k++) begin
                if (vld[k]) integ[k] <= integ[k] + integ[k-1];
            end
        end
    end

    // Decimation period: count settled integrator samples, capture the last of each period
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            r_act   <= RMIN_V;
            r_load  <= 1'b1;
            comb_in <= '0;
        end else begin
            r_load <= 1'b0;
            if (r_load) r_act <= clamp_ratio(bus.ratio);
            if (vld[N+1]) begin
                if (period_end) begin
                    cnt     <= '0;
                    comb_in <= integ[N];
                    r_act   <= clamp_ratio(bus.ratio);
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

    // Comb cascade (M = 1) driven by the decimated strobe chain
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stb <= '0;
            for (int k = 1; k <= N; k++) begin
                comb[k] <= '0;
                dly[k]  <= '0;
            end
        end else begin
            stb <= {stb[N:1], period_end};
            if (stb[1]) begin
                comb[1] <= comb_in - dly[1];
                dly[1]  <= comb_in;
            end
            for (int k = 2; k <= N; k++) begin
                if (stb[k]) begin
                    comb[k] <= comb[k-1] - dly[k];
                    dly[k]  <= comb[k-1];
                end
            end
        end
    end

    // Gain correction, rounding and saturation into the output register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= stb[N+1];
            if (stb[N+1]) out_q <= saturate(round_shift(comb[N], bus.shift));
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;

endmodule
